// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: client request/config and SPI master handshake bundle for spi_arbiter
interface spi_arbiter_if;
  logic [3:0]  Req;
  logic [7:0]  CfgMode;
  logic [31:0] TxDataIn;
  logic [7:0]  RxDataIn;
  logic        EndTx;
  logic        StartTx;
  logic        CPol;
  logic        CPha;
  logic [7:0]  TxData;
  logic [3:0]  SS_n;
  logic [3:0]  Grant;
  logic [3:0]  Done;
  logic [7:0]  RxData;
  logic        Err;
  modport slave (
    input  Req, CfgMode, TxDataIn, RxDataIn, EndTx,
    output StartTx, CPol, CPha, TxData, SS_n, Grant, Done, RxData, Err
  );
  modport master (
    output Req, CfgMode, TxDataIn, RxDataIn, EndTx,
    input  StartTx, CPol, CPha, TxData, SS_n, Grant, Done, RxData, Err
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI master among four clients with setup/hold framing and timeout
module spi_arbiter #(
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic        Clk,
  input logic        Rst_n,
  spi_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD} state_t;
  state_t      state_q;
  logic [1:0]  ptr_q, win_q, win_d, idx;
  logic        found;
  logic [15:0] cnt_q;
  logic        start_q, cpol_q, cpha_q, err_q;
  logic [7:0]  tx_q, rx_q;
  logic [3:0]  ss_n_q, grant_q, done_q;
  // search starts one past the last owner, so 2-bit wrap gives the rotation
  always_comb begin
    win_d = ptr_q;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.Req[idx]) begin
        win_d = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      win_q   <= 2'd0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      err_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      ss_n_q  <= 4'hF;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: if (found) begin
          state_q <= SETUP;
          win_q   <= win_d;
          grant_q <= 4'b0001 << win_d;
          ss_n_q  <= ~(4'b0001 << win_d);
          cpol_q  <= bus.CfgMode[{win_d, 1'b1}];
          cpha_q  <= bus.CfgMode[{win_d, 1'b0}];
          tx_q    <= bus.TxDataIn[{win_d, 3'b000} +: 8];
          cnt_q   <= '0;
        end
        SETUP: if (cnt_q == 16'(SETUP_CYC - 1)) begin
          state_q <= START;
          start_q <= 1'b1;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 16'd1;
        START: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: if (bus.EndTx) begin
          state_q <= HOLD;
          rx_q    <= bus.RxDataIn;
          done_q  <= grant_q;
          cnt_q   <= '0;
        end else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
          state_q <= HOLD;
          rx_q    <= 8'h00;
          done_q  <= grant_q;
          err_q   <= 1'b1;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 16'd1;
        HOLD: if (cnt_q == 16'(HOLD_CYC - 1)) begin
          state_q <= IDLE;
          ss_n_q  <= 4'hF;
          grant_q <= '0;
          ptr_q   <= win_q;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 16'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.StartTx = start_q;
  assign bus.CPol    = cpol_q;
  assign bus.CPha    = cpha_q;
  assign bus.TxData  = tx_q;
  assign bus.SS_n    = ss_n_q;
  assign bus.Grant   = grant_q;
  assign bus.Done    = done_q;
  assign bus.RxData  = rx_q;
  assign bus.Err     = err_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: scoreboard bench for spi_arbiter with an SPI-master responder model
module tb_spi_arbiter;
  typedef struct {logic [3:0] done; logic [7:0] rx; logic err, cpol, cpha; logic [7:0] tx;} exp_t;
  typedef struct {bit to; int dly; logic [7:0] d;} resp_t;
  logic Clk = 1'b0;
  logic Rst_n;
  logic end_r = 1'b0, end_m = 1'b0;
  logic [7:0] rx_r = 8'h00;
  int n_cmp = 0, n_err = 0;
  bit mon_en = 1'b0;
  exp_t exp_done[$];
  logic [3:0] exp_start[$];
  resp_t resp_q[$];
  spi_arbiter_if bus ();
  spi_arbiter #(.SETUP_CYC(2), .HOLD_CYC(2), .TIMEOUT_CYC(16)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
  assign bus.EndTx    = end_r | end_m;
  assign bus.RxDataIn = end_m ? 8'hEE : rx_r;
  always #5 Clk = ~Clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [3:0] g, input bit to, input int dly, input logic [7:0] d,
                      input logic cpol, input logic cpha, input logic [7:0] tx);
    exp_start.push_back(g);
    resp_q.push_back('{to, dly, d});
    exp_done.push_back('{g, to ? 8'h00 : d, to, cpol, cpha, tx});
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (bus.Done != 0) break;
    end
    chk({nm, "_done_seen"}, 32'(i < 200), 1);
  endtask
  task automatic wait_start(input string nm);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (bus.StartTx) break;
    end
    chk({nm, "_start_seen"}, 32'(i < 100), 1);
  endtask
  // SPI master model: answers each StartTx per the next queued response
  initial forever begin
    @(negedge Clk);
    if (bus.StartTx && resp_q.size() != 0) begin
      resp_t r;
      r = resp_q.pop_front();
      if (!r.to) begin
        repeat (r.dly) @(posedge Clk);
        #1 end_r = 1'b1;
        rx_r = r.d;
        @(posedge Clk);
        #1 end_r = 1'b0;
        rx_r = 8'h00;
      end
    end
  end
  always @(negedge Clk) if (mon_en) begin
    chk("ss_vs_grant", {28'b0, ~bus.SS_n}, {28'b0, bus.Grant});
    chk("grant_onehot", 32'($countones(bus.Grant) <= 1), 1);
    chk("err_wo_done", 32'(bus.Err && bus.Done == 0), 0);
    if (bus.StartTx) begin
      if (exp_start.size() == 0) chk("start_unexpected", {28'b0, bus.Grant}, 0);
      else chk("start_grant", {28'b0, bus.Grant}, {28'b0, exp_start.pop_front()});
    end
    if (bus.Done != 0) begin
      if (exp_done.size() == 0) chk("done_unexpected", {28'b0, bus.Done}, 0);
      else begin
        exp_t e;
        e = exp_done.pop_front();
        chk("done", {28'b0, bus.Done}, {28'b0, e.done});
        chk("rxdata", {24'b0, bus.RxData}, {24'b0, e.rx});
        chk("err", {31'b0, bus.Err}, {31'b0, e.err});
        chk("cpol", {31'b0, bus.CPol}, {31'b0, e.cpol});
        chk("cpha", {31'b0, bus.CPha}, {31'b0, e.cpha});
        chk("txdata", {24'b0, bus.TxData}, {24'b0, e.tx});
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int i;
    Rst_n = 1'b1;
    bus.Req = 4'h0;
    bus.CfgMode = 8'h00;
    bus.TxDataIn = 32'h0;
    #1 Rst_n = 1'b0;
    @(negedge Clk);
    chk("rst_ss_n", {28'b0, bus.SS_n}, 32'hF);
    chk("rst_grant", {28'b0, bus.Grant}, 0);
    chk("rst_done", {28'b0, bus.Done}, 0);
    chk("rst_err", {31'b0, bus.Err}, 0);
    chk("rst_start", {31'b0, bus.StartTx}, 0);
    chk("rst_cpol_cpha", {30'b0, bus.CPol, bus.CPha}, 0);
    chk("rst_txdata", {24'b0, bus.TxData}, 0);
    chk("rst_rxdata", {24'b0, bus.RxData}, 0);
    step();
    Rst_n = 1'b1;
    mon_en = 1'b1;
    // single client 0 transfer with exact edge timing
    step();
    push(4'b0001, 0, 2, 8'h3C, 1, 0, 8'hA5);
    bus.Req = 4'b0001;
    bus.CfgMode = 8'h02;
    bus.TxDataIn = 32'h000000A5;
    @(negedge Clk);
    chk("t1_idle_ss_n", {28'b0, bus.SS_n}, 32'hF);
    @(negedge Clk);
    chk("t1_e1_ss_n", {28'b0, bus.SS_n}, 32'hE);
    chk("t1_e1_grant", {28'b0, bus.Grant}, 32'h1);
    chk("t1_e1_cpol_cpha", {30'b0, bus.CPol, bus.CPha}, 32'h2);
    chk("t1_e1_txdata", {24'b0, bus.TxData}, 32'hA5);
    chk("t1_e1_start", {31'b0, bus.StartTx}, 0);
    @(negedge Clk);
    chk("t1_e2_start", {31'b0, bus.StartTx}, 0);
    @(negedge Clk);
    chk("t1_e3_start", {31'b0, bus.StartTx}, 1);
    @(negedge Clk);
    chk("t1_e4_start", {31'b0, bus.StartTx}, 0);
    wait_done("t1");
    step();
    bus.Req = 4'b0000;
    @(negedge Clk);
    chk("t1_hold_ss_n", {28'b0, bus.SS_n}, 32'hE);
    @(negedge Clk);
    chk("t1_idle_ss_n_end", {28'b0, bus.SS_n}, 32'hF);
    chk("t1_idle_grant_end", {28'b0, bus.Grant}, 0);
    // all four requesting: rotation 0,1,2,3,0 from reset priority
    step();
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    push(4'b0001, 0, 1, 8'h80, 0, 0, 8'h11);
    push(4'b0010, 0, 2, 8'h81, 0, 1, 8'h22);
    push(4'b0100, 0, 3, 8'h82, 1, 0, 8'h33);
    push(4'b1000, 0, 1, 8'h83, 1, 1, 8'h44);
    push(4'b0001, 0, 2, 8'h84, 0, 0, 8'h11);
    bus.CfgMode = 8'hE4;
    bus.TxDataIn = 32'h44332211;
    bus.Req = 4'b1111;
    for (i = 0; i < 5; i++) wait_done("t2");
    step();
    bus.Req = 4'b0000;
    repeat (4) @(negedge Clk);
    // move pointer to 1, then 0110 grants 2 before 1
    push(4'b0010, 0, 1, 8'h55, 0, 1, 8'h22);
    step();
    bus.Req = 4'b0010;
    wait_done("t3a");
    step();
    bus.Req = 4'b0000;
    repeat (3) @(negedge Clk);
    push(4'b0100, 0, 2, 8'h66, 1, 0, 8'h33);
    push(4'b0010, 0, 2, 8'h77, 0, 1, 8'h22);
    step();
    bus.Req = 4'b0110;
    wait_done("t3b");
    step();
    bus.Req = 4'b0010;
    wait_done("t3c");
    step();
    bus.Req = 4'b0000;
    repeat (3) @(negedge Clk);
    // timeout: Done+Err 16 cycles after WAIT entry, i.e. 17 negedges after START
    push(4'b0001, 1, 0, 8'h00, 0, 0, 8'h11);
    step();
    bus.Req = 4'b0001;
    wait_start("t4");
    for (i = 1; i < 100; i++) begin
      @(negedge Clk);
      if (bus.Done != 0) break;
    end
    chk("t4_timeout_latency", i, 17);
    step();
    bus.Req = 4'b0000;
    repeat (3) @(negedge Clk);
    // normal transfer after timeout, with config changed mid-WAIT
    push(4'b0100, 0, 3, 8'h9A, 1, 0, 8'h33);
    step();
    bus.Req = 4'b0100;
    wait_start("t5");
    step();
    bus.CfgMode = 8'h00;
    bus.TxDataIn = 32'hFFFFFFFF;
    @(negedge Clk);
    chk("t5_wait_cpol_cpha", {30'b0, bus.CPol, bus.CPha}, 32'h2);
    chk("t5_wait_txdata", {24'b0, bus.TxData}, 32'h33);
    wait_done("t5");
    step();
    bus.Req = 4'b0000;
    repeat (3) @(negedge Clk);
    chk("t5_idle_txdata", {24'b0, bus.TxData}, 32'h33);
    bus.CfgMode = 8'hE4;
    bus.TxDataIn = 32'h44332211;
    // reset during WAIT, then a stray EndTx in IDLE
    exp_start.push_back(4'b1000);
    resp_q.push_back('{1'b1, 0, 8'h00});
    step();
    bus.Req = 4'b1000;
    wait_start("t6");
    step();
    step();
    #2 Rst_n = 1'b0;
    #1;
    chk("t6_async_ss_n", {28'b0, bus.SS_n}, 32'hF);
    chk("t6_async_grant", {28'b0, bus.Grant}, 0);
    chk("t6_async_done", {28'b0, bus.Done}, 0);
    bus.Req = 4'b0000;
    step();
    Rst_n = 1'b1;
    step();
    end_m = 1'b1;
    step();
    end_m = 1'b0;
    @(negedge Clk);
    chk("t6_stray_ss_n", {28'b0, bus.SS_n}, 32'hF);
    chk("t6_stray_done", {28'b0, bus.Done}, 0);
    chk("t6_stray_rxdata", {24'b0, bus.RxData}, 0);
    // after reset pointer is 3 again; lone client 1 proceeds
    push(4'b0010, 0, 1, 8'h5A, 0, 1, 8'h22);
    step();
    bus.Req = 4'b0010;
    wait_done("t7");
    step();
    bus.Req = 4'b0000;
    repeat (4) @(negedge Clk);
    chk("left_exp_done", exp_done.size(), 0);
    chk("left_exp_start", exp_start.size(), 0);
    chk("left_resp", resp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
